// File: rtl/rip_fifo_pkg.sv
// rtl/rip_fifo_pkg.sv - shared types, constants and helpers for rip_fifo_sync
//   fifo_err_t              : packed sticky error pair {ovf, udf}
//   RIP_FIFO_MIN_ADDR_WIDTH : smallest legal ADDR_WIDTH
//   thresh_ok()             : range test used by elaboration-time parameter checks
package rip_fifo_pkg;

   typedef struct packed {
      logic ovf;
      logic udf;
   } fifo_err_t;

   localparam int RIP_FIFO_MIN_ADDR_WIDTH = 1;

   function automatic bit thresh_ok(input int val, input int lo, input int hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/rip_fifo_ram.sv
// rtl/rip_fifo_ram.sv - simple dual-port storage array with registered read port
//   clk       : clock, write and read both on posedge
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write payload
//   rd_addr_i : read address, sampled every cycle
//   rd_data_o : registered read data (old contents on same-address write)
module rip_fifo_ram
   import rip_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_q <= mem_q[rd_addr_i];
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rip_fifo_sync.sv
// rtl/rip_fifo_sync.sv - single-clock FWFT FIFO with count, thresholds, flush and error flags
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of pointers, count and head (array and errors kept)
//   w_en/w_data: write request and payload
//   r_en       : pop request, acknowledges r_data
//   r_data     : head register, valid whenever !r_empty
//   w_full, r_empty, w_afull, r_aempty, count : registered-state status
//   err_ovf, err_udf : sticky errors when RIP_FIFO_SYNC_ERR_EN is defined, else tied 0
module rip_fifo_sync
   import rip_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 128,
   parameter int ADDR_WIDTH    = 8,
   parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  w_full,
   output logic                  r_empty,
   output logic                  w_afull,
   output logic                  r_aempty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  err_ovf,
   output logic                  err_udf
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

   if (ADDR_WIDTH < RIP_FIFO_MIN_ADDR_WIDTH) begin : g_bad_addr_width
      $error("rip_fifo_sync: ADDR_WIDTH below minimum");
   end
   if (!thresh_ok(AFULL_THRESH, 1, DEPTH)) begin : g_bad_afull
      $error("rip_fifo_sync: AFULL_THRESH out of range 1..DEPTH");
   end
   if (!thresh_ok(AEMPTY_THRESH, 0, DEPTH - 1)) begin : g_bad_aempty
      $error("rip_fifo_sync: AEMPTY_THRESH out of range 0..DEPTH-1");
   end

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  head_vld_q, head_vld_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic                  fwd_q, fwd_d;
   logic [DATA_WIDTH-1:0] fwd_data_q;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] arr_head;
   logic                  wr_acc, rd_acc, head_free, arr_avail, bypass, arr_we;

   // Status is decoded only from registered state.
   assign w_full   = (count_q == DEPTH_C);
   assign r_empty  = !head_vld_q;
   assign w_afull  = (count_q >= AFULL_C);
   assign r_aempty = (count_q <= AEMPTY_C);
   assign count    = count_q;
   assign r_data   = head_q;

   // The RAM reads at the next read pointer, so its output register already
   // holds the oldest array entry. A write landing on that same address in the
   // same cycle returns stale data, so that word is held aside for one cycle.
   assign arr_head = fwd_q ? fwd_data_q : ram_rdata;

   always_comb begin
      wr_acc     = w_en && !w_full;
      rd_acc     = r_en && !r_empty;
      head_free  = !head_vld_q || rd_acc;
      arr_avail  = (wr_ptr_q != rd_ptr_q);
      bypass     = head_free && !arr_avail && wr_acc;
      arr_we     = wr_acc && !bypass && !flush;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      head_d     = head_q;
      head_vld_d = head_vld_q;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         head_vld_d = 1'b0;
      end else begin
         if (arr_we) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
         end
         if (head_free) begin
            if (arr_avail) begin
               head_d     = arr_head;
               head_vld_d = 1'b1;
               rd_ptr_d   = rd_ptr_q + ONE_C;
            end else if (wr_acc) begin
               head_d     = w_data;
               head_vld_d = 1'b1;
            end else begin
               head_vld_d = 1'b0;
            end
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
         endcase
      end

      fwd_d = arr_we && (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         head_vld_q <= 1'b0;
         fwd_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         head_q     <= head_d;
         head_vld_q <= head_vld_d;
         fwd_q      <= fwd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fwd_d) begin
         fwd_data_q <= w_data;
      end
   end

   rip_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (arr_we),
      .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wr_data_i (w_data),
      .rd_addr_i (rd_ptr_d[ADDR_WIDTH-1:0]),
      .rd_data_o (ram_rdata)
   );

`ifdef RIP_FIFO_SYNC_ERR_EN
   fifo_err_t err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (!flush) begin
         if (w_en && w_full) begin
            err_d.ovf = 1'b1;
         end
         if (r_en && r_empty) begin
            err_d.udf = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_ovf = err_q.ovf;
   assign err_udf = err_q.udf;
`else
   assign err_ovf = 1'b0;
   assign err_udf = 1'b0;
`endif

endmodule
